// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants, response-byte filter and byte FSM states for the PS/2 key decoder
package ps2_pkg;
    localparam logic [7:0] PS2_EXT      = 8'hE0;
    localparam logic [7:0] PS2_BRK      = 8'hF0;
    localparam logic [7:0] PS2_PAUSE    = 8'hE1;
    localparam logic [2:0] PS2_SKIP_LEN = 3'd7;
    localparam logic [5:0][7:0] PS2_RESP = {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

    typedef enum logic [1:0] {ST_IDLE, ST_PREFIX, ST_SKIP} byte_state_t;

    function automatic logic is_response(input logic [7:0] b);
        is_response = 1'b0;
        for (int i = 0; i < 6; i++) is_response |= (b == PS2_RESP[i]);
    endfunction
endpackage

// File: rtl/ps2_key_decoder_if.sv
// ps2_key_decoder_if: raw PS/2 lines in, decoded key event word and pulses out
interface ps2_key_decoder_if;
    logic        ps2_clk;
    logic        ps2_data;
    logic [10:0] ps2_key;
    logic        key_strobe;
    logic        frame_err;
    modport master (output ps2_clk, ps2_data, input ps2_key, key_strobe, frame_err);
    modport slave  (input ps2_clk, ps2_data, output ps2_key, key_strobe, frame_err);
endinterface

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: synchronise and filter the PS/2 lines, shift in 11-bit frames, check parity/stop, time out stalls
module ps2_frame_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 8,
    parameter int TIMEOUT     = 96000
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] data,
    output logic       byte_vld,
    output logic       perr,
    output logic       terr
);
    localparam int FW = $clog2(FILT_LEN) + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [FW-1:0] FILT_MAX = FW'(FILT_LEN - 1);
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT - 1);

    logic [SYNC_STAGES-1:0] clk_sr, dat_sr;
    logic [FW-1:0] fcnt;
    logic [TW-1:0] timer;
    logic [3:0] bit_cnt;
    logic [7:0] sr;
    logic filt_clk, par, s_clk, s_dat, settle, fall, stop_ok;

    assign s_clk    = clk_sr[SYNC_STAGES-1];
    assign s_dat    = dat_sr[SYNC_STAGES-1];
    assign settle   = (s_clk != filt_clk) && (fcnt == FILT_MAX);
    assign fall     = settle && filt_clk;
    assign stop_ok  = s_dat && (^{sr, par});
    assign byte_vld = fall && (bit_cnt == 4'd10) && stop_ok;
    assign perr     = fall && (bit_cnt == 4'd10) && !stop_ok;
    assign terr     = (bit_cnt != 4'd0) && !fall && (timer == TO_MAX);
    assign data     = sr;

    // Bring the asynchronous lines into clk_sys; idle-high reset avoids a false edge
    always_ff @(posedge clk_sys) begin
        clk_sr <= reset ? '1 : {clk_sr[SYNC_STAGES-2:0], ps2_clk};
        dat_sr <= reset ? '1 : {dat_sr[SYNC_STAGES-2:0], ps2_data};
    end

    // Glitch filter: the clock level only changes after FILT_LEN stable cycles
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            fcnt     <= '0;
            filt_clk <= 1'b1;
        end else begin
            fcnt     <= (s_clk == filt_clk || settle) ? '0 : fcnt + 1'b1;
            filt_clk <= settle ? s_clk : filt_clk;
        end
    end

    // Frame shifter: start bit gates entry, data LSB first, then parity, then stop
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            bit_cnt <= 4'd0;
            sr      <= 8'd0;
            par     <= 1'b0;
            timer   <= '0;
        end else if (fall) begin
            timer   <= '0;
            bit_cnt <= (bit_cnt == 4'd0) ? {3'b0, ~s_dat} : (bit_cnt == 4'd10) ? 4'd0 : bit_cnt + 4'd1;
            sr      <= (bit_cnt >= 4'd1 && bit_cnt <= 4'd8) ? {s_dat, sr[7:1]} : sr;
            par     <= (bit_cnt == 4'd9) ? s_dat : par;
        end else if (terr) begin
            bit_cnt <= 4'd0;
            timer   <= '0;
        end else begin
            timer   <= (bit_cnt == 4'd0) ? '0 : timer + 1'b1;
        end
    end
endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: set-2 scancode decoder with E0/F0 prefixes, Pause skipping and toggle-flagged events
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 8,
    parameter int TIMEOUT     = 96000
) (
    input logic clk_sys,
    input logic reset,
    ps2_key_decoder_if.slave bus
);
    byte_state_t state, state_n;
    logic [10:0] key, key_n;
    logic [7:0] rx_byte;
    logic [2:0] skip_cnt, skip_n;
    logic ext, ext_n, rel, rel_n, strobe, strobe_n, err, err_n;
    logic byte_vld, perr, terr;

    ps2_frame_rx #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN), .TIMEOUT(TIMEOUT)) u_rx (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .ps2_clk  (bus.ps2_clk),
        .ps2_data (bus.ps2_data),
        .data     (rx_byte),
        .byte_vld (byte_vld),
        .perr     (perr),
        .terr     (terr)
    );

    assign bus.ps2_key    = key;
    assign bus.key_strobe = strobe;
    assign bus.frame_err  = err;

    // Decoder state register
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state    <= ST_IDLE;
            key      <= 11'd0;
            skip_cnt <= 3'd0;
            ext      <= 1'b0;
            rel      <= 1'b0;
            strobe   <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            key      <= key_n;
            skip_cnt <= skip_n;
            ext      <= ext_n;
            rel      <= rel_n;
            strobe   <= strobe_n;
            err      <= err_n;
        end
    end

    // Prefix tracking, Pause skipping and event emission; timeouts keep prefixes, bad frames clear them
    always_comb begin
        state_n  = state;
        key_n    = key;
        skip_n   = skip_cnt;
        ext_n    = ext;
        rel_n    = rel;
        strobe_n = 1'b0;
        err_n    = perr | terr;
        if (perr) begin
            state_n = ST_IDLE;
            ext_n   = 1'b0;
            rel_n   = 1'b0;
        end else if (byte_vld && state == ST_SKIP) begin
            skip_n  = skip_cnt - 3'd1;
            state_n = (skip_cnt == 3'd1) ? ST_IDLE : ST_SKIP;
        end else if (byte_vld) begin
            if (rx_byte == PS2_EXT) begin
                ext_n   = 1'b1;
                state_n = ST_PREFIX;
            end else if (rx_byte == PS2_BRK) begin
                rel_n   = 1'b1;
                state_n = ST_PREFIX;
            end else if (rx_byte == PS2_PAUSE) begin
                state_n = ST_SKIP;
                skip_n  = PS2_SKIP_LEN;
                ext_n   = 1'b0;
                rel_n   = 1'b0;
            end else if (!is_response(rx_byte)) begin
                key_n    = {~key[10], ~rel, ext, rx_byte};
                strobe_n = 1'b1;
                ext_n    = 1'b0;
                rel_n    = 1'b0;
                state_n  = ST_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: table-driven frame vectors plus hand sequences for timeout, noise and reset
module tb_ps2_key_decoder;
    localparam int HALF    = 20;
    localparam int TIMEOUT = 300;

    typedef struct {
        logic [71:0] seq;
        int          n;
        logic [8:0]  flip;
        int          exp_strobes;
        int          exp_errs;
        logic [10:0] exp_key;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int compared = 0;
    int mismatched = 0;
    int strobes = 0;
    int errs = 0;
    int s0, e0;
    vec_t vec [11];

    ps2_key_decoder_if bus ();

    ps2_key_decoder #(.SYNC_STAGES(2), .FILT_LEN(8), .TIMEOUT(TIMEOUT)) dut (
        .clk_sys (clk),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.key_strobe) strobes++;
        if (bus.frame_err) errs++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            bus.ps2_data = f[i];
            repeat (HALF) @(negedge clk);
            bus.ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            bus.ps2_clk = 1'b1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic flip);
        send_bits({1'b1, ~^b ^ flip, b, 1'b0}, 11);
        bus.ps2_data = 1'b1;
        repeat (3 * HALF) @(negedge clk);
    endtask

    task automatic expect_delta(input string name, input int ds, input int de, input logic [10:0] k);
        check({name, " strobes"}, strobes - s0, ds);
        check({name, " errs"}, errs - e0, de);
        check({name, " key"}, {21'd0, bus.ps2_key}, {21'd0, k});
    endtask

    initial begin
        vec[0]  = '{72'h29,                 1, 9'b0,   1, 0, 11'h629};
        vec[1]  = '{72'hF029,               2, 9'b0,   1, 0, 11'h029};
        vec[2]  = '{72'hE0F06B,             3, 9'b0,   1, 0, 11'h56B};
        vec[3]  = '{72'hE11477E1F014F07716, 9, 9'b0,   1, 0, 11'h216};
        vec[4]  = '{72'h1C,                 1, 9'b1,   0, 1, 11'h216};
        vec[5]  = '{72'h1C,                 1, 9'b0,   1, 0, 11'h61C};
        vec[6]  = '{72'hAA,                 1, 9'b0,   0, 0, 11'h61C};
        vec[7]  = '{72'hE0E075,             3, 9'b0,   1, 0, 11'h375};
        vec[8]  = '{72'hE0F0F011,           4, 9'b0,   1, 0, 11'h511};
        vec[9]  = '{72'hE01C1C,             3, 9'b010, 1, 1, 11'h21C};
        vec[10] = '{72'hFE00FFEEFA,         5, 9'b0,   0, 0, 11'h21C};

        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        check("reset key", {21'd0, bus.ps2_key}, 32'd0);
        check("reset strobe", {31'd0, bus.key_strobe}, 32'd0);
        check("reset err", {31'd0, bus.frame_err}, 32'd0);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        for (int v = 0; v < 11; v++) begin
            s0 = strobes;
            e0 = errs;
            for (int j = 0; j < vec[v].n; j++)
                send_byte(vec[v].seq[8 * (vec[v].n - 1 - j) +: 8], vec[v].flip[j]);
            expect_delta($sformatf("vec%0d", v), vec[v].exp_strobes, vec[v].exp_errs, vec[v].exp_key);
        end

        s0 = strobes;
        e0 = errs;
        send_bits({2'b11, 8'h2E, 1'b0}, 5);
        repeat (TIMEOUT + 100) @(negedge clk);
        expect_delta("timeout", 0, 1, 11'h21C);
        s0 = strobes;
        e0 = errs;
        send_byte(8'h2E, 1'b0);
        expect_delta("after timeout", 1, 0, 11'h62E);

        s0 = strobes;
        e0 = errs;
        send_byte(8'hE0, 1'b0);
        send_bits({2'b11, 8'h2E, 1'b0}, 5);
        repeat (TIMEOUT + 100) @(negedge clk);
        send_byte(8'h2E, 1'b0);
        expect_delta("prefix kept", 1, 1, 11'h32E);

        s0 = strobes;
        e0 = errs;
        send_bits(11'h7FF, 1);
        repeat (3 * HALF) @(negedge clk);
        send_byte(8'h29, 1'b0);
        expect_delta("start noise", 1, 0, 11'h629);

        send_bits({2'b11, 8'h2E, 1'b0}, 5);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("midreset key", {21'd0, bus.ps2_key}, 32'd0);
        check("midreset strobe", {31'd0, bus.key_strobe}, 32'd0);
        check("midreset err", {31'd0, bus.frame_err}, 32'd0);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        s0 = strobes;
        e0 = errs;
        send_byte(8'h29, 1'b0);
        expect_delta("after reset", 1, 0, 11'h629);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
